ppi8255_hs: RTL and testbench

//  Parallel interface (КР580ВВ55 / i8255 class) with a control-word register, per-group direction control,

---
 rtl/ppi8255_hs.sv | 209 ++++++++++++++++++++
 tb/tb_ppi8255_hs.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ppi8255_hs.sv
// i8255-class parallel interface: control word, per-group direction, mode 0 basic I/O,
// mode 1 strobed I/O with IBF/OBF/INTR handshake on ports A and B, port C bit set/reset.
module ppi8255_hs #(
    parameter logic [6:0]  RESET_MODE  = 7'h1B,
    parameter logic [7:0]  OUT_RESET   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       we_n,
    input  logic       rd_n,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    input  logic [7:0] ipa,
    input  logic [7:0] ipb,
    input  logic [7:0] ipc,
    output logic [7:0] opa,
    output logic [7:0] opb,
    output logic [7:0] opc,
    output logic [7:0] oea,
    output logic [7:0] oeb,
    output logic [7:0] oec,
    output logic       intr_a,
    output logic       intr_b
);

    logic [6:0] r_mode;
    logic [7:0] r_opa, r_opb, r_opc, r_ina, r_inb;
    logic       r_ibf_a, r_ibf_b, r_obf_a_n, r_obf_b_n;
    logic       r_inte_a, r_inte_b, r_intr_a, r_intr_b;
    logic       r_rd_n_d;
    logic [2:0] r_sync [SYNC_STAGES];
    logic [2:0] r_edge;

    logic       w_a_m1, w_a_in, w_b_m1, w_b_in;
    logic [7:0] w_hs_drv, w_hs_pin, w_hs, w_hs_val, w_oec, w_opc;
    logic [2:0] w_fall, w_rise, w_bsr_bit;
    logic       w_wr, w_rd_fall, w_ctl_wr, w_bsr_wr;
    logic       w_wr_a, w_wr_b, w_wr_c, w_rd_a, w_rd_b;

    // Mode 2 (D6=1) is folded into mode 1 for group A.
    assign w_a_m1 = r_mode[6] | r_mode[5];
    assign w_a_in = r_mode[4];
    assign w_b_m1 = r_mode[2];
    assign w_b_in = r_mode[1];

    always_comb begin
        w_hs_drv = '0;
        w_hs_pin = '0;
        w_hs_val = '0;
        if (w_a_m1) begin
            w_hs_drv[3] = 1'b1;
            w_hs_val[3] = r_intr_a;
            if (w_a_in) begin
                w_hs_pin[4] = 1'b1;
                w_hs_drv[5] = 1'b1;
                w_hs_val[5] = r_ibf_a;
            end else begin
                w_hs_pin[6] = 1'b1;
                w_hs_drv[7] = 1'b1;
                w_hs_val[7] = r_obf_a_n;
            end
        end
        if (w_b_m1) begin
            w_hs_drv[1:0] = 2'b11;
            w_hs_pin[2]   = 1'b1;
            w_hs_val[0]   = r_intr_b;
            w_hs_val[1]   = w_b_in ? r_ibf_b : r_obf_b_n;
        end
    end

    assign w_hs  = w_hs_drv | w_hs_pin;
    assign w_oec = ({{4{~r_mode[3]}}, {4{~r_mode[0]}}} & ~w_hs) | w_hs_drv;
    assign w_opc = (r_opc & ~w_hs_drv) | (w_hs_val & w_hs_drv);

    assign opa    = r_opa;
    assign opb    = r_opb;
    assign opc    = w_opc;
    assign oea    = w_a_in ? 8'h00 : 8'hFF;
    assign oeb    = w_b_in ? 8'h00 : 8'hFF;
    assign oec    = w_oec;
    assign intr_a = r_intr_a;
    assign intr_b = r_intr_b;

    // Synchronised pin bits: [0]=PC2 (STBB_n/ACKB_n), [1]=PC4 (STBA_n), [2]=PC6 (ACKA_n).
    assign w_fall = r_edge & ~r_sync[SYNC_STAGES-1];
    assign w_rise = ~r_edge & r_sync[SYNC_STAGES-1];

    assign w_wr      = ~we_n;
    assign w_rd_fall = r_rd_n_d & ~rd_n;
    assign w_ctl_wr  = w_wr && addr == 2'd3 && idata[7];
    assign w_bsr_wr  = w_wr && addr == 2'd3 && !idata[7];
    assign w_bsr_bit = idata[3:1];
    assign w_wr_a    = w_wr && addr == 2'd0;
    assign w_wr_b    = w_wr && addr == 2'd1;
    assign w_wr_c    = w_wr && addr == 2'd2;
    assign w_rd_a    = w_rd_fall && addr == 2'd0;
    assign w_rd_b    = w_rd_fall && addr == 2'd1;

    always_comb begin
        odata = '0;
        case (addr)
            2'd0:    odata = w_a_in ? (w_a_m1 ? r_ina : ipa) : r_opa;
            2'd1:    odata = w_b_in ? (w_b_m1 ? r_inb : ipb) : r_opb;
            2'd2:    odata = (ipc & ~w_oec) | (w_opc & w_oec);
            default: odata = {1'b1, r_mode};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
            r_edge <= '1;
        end else begin
            r_sync[0] <= {ipc[6], ipc[4], ipc[2]};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode    <= RESET_MODE;
            r_opa     <= OUT_RESET;
            r_opb     <= OUT_RESET;
            r_opc     <= OUT_RESET;
            r_ina     <= '0;
            r_inb     <= '0;
            r_ibf_a   <= 1'b0;
            r_ibf_b   <= 1'b0;
            r_obf_a_n <= 1'b1;
            r_obf_b_n <= 1'b1;
            r_inte_a  <= 1'b0;
            r_inte_b  <= 1'b0;
            r_intr_a  <= 1'b0;
            r_intr_b  <= 1'b0;
            r_rd_n_d  <= 1'b1;
        end else begin
            r_rd_n_d <= rd_n;
            if (w_ctl_wr) begin
                r_mode    <= idata[6:0];
                r_opa     <= '0;
                r_opb     <= '0;
                r_opc     <= '0;
                r_ibf_a   <= 1'b0;
                r_ibf_b   <= 1'b0;
                r_obf_a_n <= 1'b1;
                r_obf_b_n <= 1'b1;
                r_inte_a  <= 1'b0;
                r_inte_b  <= 1'b0;
                r_intr_a  <= 1'b0;
                r_intr_b  <= 1'b0;
            end else begin
                if (w_bsr_wr) begin
                    if (w_hs_pin[w_bsr_bit]) begin
                        if (w_bsr_bit == 3'd2) r_inte_b <= idata[0];
                        else                   r_inte_a <= idata[0];
                    end else if (!w_hs_drv[w_bsr_bit]) begin
                        r_opc[w_bsr_bit] <= idata[0];
                    end
                end
                if (w_wr_a) r_opa <= idata;
                if (w_wr_b) r_opb <= idata;
                if (w_wr_c) r_opc <= (r_opc & w_hs) | (idata & ~w_hs);

                // Later assignments take priority: read clears, then a strobe fall re-sets IBF.
                if (w_a_m1 && w_a_in) begin
                    if (w_rise[1] && r_ibf_a && r_inte_a) r_intr_a <= 1'b1;
                    if (w_rd_a) begin
                        r_ibf_a  <= 1'b0;
                        r_intr_a <= 1'b0;
                    end
                    if (w_fall[1]) begin
                        r_ina   <= ipa;
                        r_ibf_a <= 1'b1;
                    end
                end else if (w_a_m1) begin
                    if (w_rise[2] && r_obf_a_n && r_inte_a) r_intr_a <= 1'b1;
                    if (w_fall[2]) r_obf_a_n <= 1'b1;
                    if (w_wr_a) begin
                        r_obf_a_n <= 1'b0;
                        r_intr_a  <= 1'b0;
                    end
                end

                if (w_b_m1 && w_b_in) begin
                    if (w_rise[0] && r_ibf_b && r_inte_b) r_intr_b <= 1'b1;
                    if (w_rd_b) begin
                        r_ibf_b  <= 1'b0;
                        r_intr_b <= 1'b0;
                    end
                    if (w_fall[0]) begin
                        r_inb   <= ipb;
                        r_ibf_b <= 1'b1;
                    end
                end else if (w_b_m1) begin
                    if (w_rise[0] && r_obf_b_n && r_inte_b) r_intr_b <= 1'b1;
                    if (w_fall[0]) r_obf_b_n <= 1'b1;
                    if (w_wr_b) begin
                        r_obf_b_n <= 1'b0;
                        r_intr_b  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppi8255_hs.sv
// Directed bench for ppi8255_hs: mode 0 I/O, BSR, mode 1 input/output handshakes,
// read/strobe collision and asynchronous reset during a handshake.
module tb_ppi8255_hs;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr;
    logic       we_n, rd_n;
    logic [7:0] idata, odata;
    logic [7:0] ipa, ipb, ipc;
    logic [7:0] opa, opb, opc, oea, oeb, oec;
    logic       intr_a, intr_b;
    logic [7:0] rdat;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ppi8255_hs #(.RESET_MODE(7'h1B), .OUT_RESET(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we_n(we_n), .rd_n(rd_n),
        .idata(idata), .odata(odata), .ipa(ipa), .ipb(ipb), .ipc(ipc),
        .opa(opa), .opb(opb), .opc(opc), .oea(oea), .oeb(oeb), .oec(oec),
        .intr_a(intr_a), .intr_b(intr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end at a falling clock edge.
    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; idata = d; we_n = 1'b0;
        @(negedge clk);
        we_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
        addr = a; rd_n = 1'b0;
        #1 d = odata;
        @(negedge clk);
        rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_neg(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; addr = 2'd0; we_n = 1'b1; rd_n = 1'b1; idata = '0;
        ipa = '0; ipb = '0; ipc = 8'hFF;
        wait_neg(3);
        reset = 1'b0;
        @(negedge clk);

        check("rst_opa", opa, 8'hFF);
        check("rst_opb", opb, 8'hFF);
        check("rst_opc", opc, 8'hFF);
        check("rst_oea", oea, 8'h00);
        check("rst_oeb", oeb, 8'h00);
        check("rst_oec", oec, 8'h00);
        check("rst_intr", {6'b0, intr_a, intr_b}, 8'h00);
        cpu_rd(2'd3, rdat);
        check("rst_ctl", rdat, 8'h9B);

        // Mode 0, all outputs
        cpu_wr(2'd3, 8'h80);
        cpu_wr(2'd0, 8'h55);
        cpu_wr(2'd2, 8'h0F);
        cpu_wr(2'd3, 8'h0F);
        check("m0_opa", opa, 8'h55);
        check("m0_oea", oea, 8'hFF);
        check("m0_opc", opc, 8'h8F);
        check("m0_opb", opb, 8'h00);
        check("m0_oec", oec, 8'hFF);
        cpu_rd(2'd0, rdat);
        check("m0_rdA", rdat, 8'h55);

        // Mode 1 input on A
        cpu_wr(2'd3, 8'hB0);
        cpu_wr(2'd3, 8'h09);
        check("m1i_oec", oec, 8'hEF);
        check("m1i_oea", oea, 8'h00);
        check("m1i_opc", opc, 8'h00);
        ipa = 8'h3C;
        ipc = 8'hEF;
        wait_neg(2);
        check("m1i_ibf_2clk", {7'b0, opc[5]}, 8'h00);
        wait_neg(1);
        check("m1i_ibf_3clk", {7'b0, opc[5]}, 8'h01);
        check("m1i_intr_low", {7'b0, intr_a}, 8'h00);
        ipc = 8'hFF;
        wait_neg(3);
        check("m1i_intr_set", {7'b0, intr_a}, 8'h01);
        check("m1i_pc3", {7'b0, opc[3]}, 8'h01);
        cpu_rd(2'd0, rdat);
        check("m1i_rdA", rdat, 8'h3C);
        check("m1i_ibf_clr", {7'b0, opc[5]}, 8'h00);
        check("m1i_intr_clr", {7'b0, intr_a}, 8'h00);

        // Mode 1 output on A
        cpu_wr(2'd3, 8'hA0);
        check("m1o_opc_idle", opc, 8'h80);
        check("m1o_oec", oec, 8'hBF);
        cpu_wr(2'd3, 8'h0D);
        cpu_wr(2'd0, 8'hA5);
        check("m1o_opa", opa, 8'hA5);
        check("m1o_obf_low", {7'b0, opc[7]}, 8'h00);
        ipc = 8'hBF;
        wait_neg(2);
        ipc = 8'hFF;
        wait_neg(1);
        check("m1o_obf_high", {7'b0, opc[7]}, 8'h01);
        check("m1o_intr_wait", {7'b0, intr_a}, 8'h00);
        wait_neg(2);
        check("m1o_intr_set", {7'b0, intr_a}, 8'h01);
        cpu_wr(2'd0, 8'h11);
        check("m1o_intr_clr", {7'b0, intr_a}, 8'h00);
        check("m1o_obf_again", {7'b0, opc[7]}, 8'h00);

        // Mode 1 input on B, strobe fall colliding with a CPU read
        cpu_wr(2'd3, 8'h86);
        cpu_wr(2'd3, 8'h05);
        check("m1b_oec", oec, 8'hFB);
        ipb = 8'h11;
        ipc = 8'hFB;
        wait_neg(3);
        ipc = 8'hFF;
        wait_neg(3);
        check("m1b_ibf", {7'b0, opc[1]}, 8'h01);
        check("m1b_intr", {7'b0, intr_b}, 8'h01);
        ipb = 8'h22;
        ipc = 8'hFB;
        wait_neg(2);
        addr = 2'd1; rd_n = 1'b0;
        #1 rdat = odata;
        check("m1b_rd_old", rdat, 8'h11);
        @(negedge clk);
        rd_n = 1'b1;
        check("col_ibf", {7'b0, opc[1]}, 8'h01);
        check("col_intr", {7'b0, intr_b}, 8'h00);
        @(negedge clk);
        cpu_rd(2'd1, rdat);
        check("col_data", rdat, 8'h22);
        check("col_ibf_clr", {7'b0, opc[1]}, 8'h00);

        // Asynchronous reset mid-handshake
        ipc = 8'hFF;
        wait_neg(4);
        cpu_wr(2'd3, 8'hB0);
        cpu_wr(2'd3, 8'h09);
        ipa = 8'h77;
        ipc = 8'hEF;
        wait_neg(3);
        ipc = 8'hFF;
        wait_neg(3);
        check("ar_ibf", {7'b0, opc[5]}, 8'h01);
        check("ar_intr", {7'b0, intr_a}, 8'h01);
        addr = 2'd3;
        #2 reset = 1'b1;
        #1;
        check("ar_intr_async", {7'b0, intr_a}, 8'h00);
        check("ar_ctl", odata, 8'h9B);
        check("ar_opc", opc, 8'hFF);
        check("ar_oec", oec, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ar_post_intr", {7'b0, intr_a}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
